// File: rtl/nettlp_cmd_pkg.sv
// Shared NetTLP register-command FIFO word and opcode definitions.
package nettlp_cmd_pkg;

  localparam logic [7:0] NETTLP_OPC_REG_WR = 8'h01;
  localparam logic [7:0] NETTLP_OPC_REG_RD = 8'h02;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] dwaddr;
    logic [31:0] data;
  } FIFO_NETTLP_CMD_T;

endpackage

// File: rtl/nettlp_cmd_arb.sv
// Round-robin sharing of the NetTLP register-command engine between NREQ
// command FIFOs, with one outstanding read and response routing/timeout.
module nettlp_cmd_arb
  import nettlp_cmd_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [NREQ-1:0]             req_rd_en,
  input  logic [NREQ-1:0]             req_empty,
  input  FIFO_NETTLP_CMD_T [NREQ-1:0] req_dout,
  output logic                        core_wr_en,
  input  logic                        core_full,
  output FIFO_NETTLP_CMD_T            core_din,
  output logic                        core_rsp_rd_en,
  input  logic                        core_rsp_empty,
  input  FIFO_NETTLP_CMD_T            core_rsp_dout,
  output logic [NREQ-1:0]             rsp_wr_en,
  input  logic [NREQ-1:0]             rsp_full,
  output FIFO_NETTLP_CMD_T            rsp_din,
  output logic [15:0]                 stat_drop_cnt,
  output logic                        busy
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(RSP_TIMEOUT);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CMD_GAP  = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] RSP_GAP  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [GW-1:0]    last_grant, last_grant_nxt;
  logic [GW-1:0]    owner, owner_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic [NREQ-1:0]  req_rd_en_nxt, rsp_wr_en_nxt;
  logic             core_wr_en_nxt, core_rsp_rd_en_nxt;
  FIFO_NETTLP_CMD_T core_din_nxt, rsp_din_nxt;
  logic             drop_inc;
  logic [15:0]      stat_drop_cnt_nxt;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [GW-1:0]    grant, cand;

  // Valid commands need engine FIFO room; bad opcodes are dropped regardless.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      elig[i] = !req_empty[i] &&
                !(core_full && ((req_dout[i].opcode == NETTLP_OPC_REG_WR) ||
                                (req_dout[i].opcode == NETTLP_OPC_REG_RD)));
    end
  end

  // Rotating-priority search starting after the previous winner.
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    cand  = last_grant;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = GW'((int'(last_grant) + k) % int'(NREQ));
      if (!found && elig[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    last_grant_nxt     = last_grant;
    owner_nxt          = owner;
    tmo_cnt_nxt        = tmo_cnt;
    rd_pend_nxt        = rd_pend;
    req_rd_en_nxt      = '0;
    rsp_wr_en_nxt      = '0;
    core_wr_en_nxt     = 1'b0;
    core_rsp_rd_en_nxt = 1'b0;
    core_din_nxt       = core_din;
    rsp_din_nxt        = rsp_din;
    drop_inc           = 1'b0;
    case (state)
      IDLE: begin
        if (!core_rsp_empty) begin
          // Response with no read outstanding: discard it.
          core_rsp_rd_en_nxt = 1'b1;
          drop_inc           = 1'b1;
          rd_pend_nxt        = 1'b0;
          state_nxt          = CMD_GAP;
        end else if (found) begin
          last_grant_nxt       = grant;
          req_rd_en_nxt[grant] = 1'b1;
          rd_pend_nxt          = 1'b0;
          state_nxt            = CMD_GAP;
          case (req_dout[grant].opcode)
            NETTLP_OPC_REG_WR: begin
              core_wr_en_nxt = 1'b1;
              core_din_nxt   = req_dout[grant];
            end
            NETTLP_OPC_REG_RD: begin
              core_wr_en_nxt = 1'b1;
              core_din_nxt   = req_dout[grant];
              owner_nxt      = grant;
              tmo_cnt_nxt    = '0;
              rd_pend_nxt    = 1'b1;
            end
            default: drop_inc = 1'b1;
          endcase
        end
      end
      CMD_GAP: state_nxt = rd_pend ? WAIT_RSP : IDLE;
      WAIT_RSP: begin
        if (rsp_full[owner]) begin
          state_nxt = WAIT_RSP;
        end else if (!core_rsp_empty) begin
          core_rsp_rd_en_nxt   = 1'b1;
          rsp_wr_en_nxt[owner] = 1'b1;
          rsp_din_nxt          = core_rsp_dout;
          state_nxt            = RSP_GAP;
        end else if (tmo_cnt == TW'(RSP_TIMEOUT - 1)) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      RSP_GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    stat_drop_cnt_nxt = (drop_inc && (stat_drop_cnt != 16'hFFFF)) ?
                        stat_drop_cnt + 16'd1 : stat_drop_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= GW'(NREQ - 1);
      owner          <= '0;
      tmo_cnt        <= '0;
      rd_pend        <= 1'b0;
      req_rd_en      <= '0;
      rsp_wr_en      <= '0;
      core_wr_en     <= 1'b0;
      core_rsp_rd_en <= 1'b0;
      core_din       <= '0;
      rsp_din        <= '0;
      stat_drop_cnt  <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      last_grant     <= last_grant_nxt;
      owner          <= owner_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
      rd_pend        <= rd_pend_nxt;
      req_rd_en      <= req_rd_en_nxt;
      rsp_wr_en      <= rsp_wr_en_nxt;
      core_wr_en     <= core_wr_en_nxt;
      core_rsp_rd_en <= core_rsp_rd_en_nxt;
      core_din       <= core_din_nxt;
      rsp_din        <= rsp_din_nxt;
      stat_drop_cnt  <= stat_drop_cnt_nxt;
      busy           <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_nettlp_cmd_arb.sv
// Scoreboard bench for nettlp_cmd_arb with FWFT FIFO models on every side.
module tb_nettlp_cmd_arb;
  import nettlp_cmd_pkg::*;

  localparam int unsigned NREQ        = 2;
  localparam int unsigned RSP_TIMEOUT = 16;
  localparam logic [31:0] MAGIC       = 32'h0000_0000;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NREQ-1:0]             req_rd_en;
  logic [NREQ-1:0]             req_empty;
  FIFO_NETTLP_CMD_T [NREQ-1:0] req_dout;
  logic                        core_wr_en;
  logic                        core_full;
  FIFO_NETTLP_CMD_T            core_din;
  logic                        core_rsp_rd_en;
  logic                        core_rsp_empty;
  FIFO_NETTLP_CMD_T            core_rsp_dout;
  logic [NREQ-1:0]             rsp_wr_en;
  logic [NREQ-1:0]             rsp_full;
  FIFO_NETTLP_CMD_T            rsp_din;
  logic [15:0]                 stat_drop_cnt;
  logic                        busy;

  always #5 clk = ~clk;

  nettlp_cmd_arb #(.NREQ(NREQ), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(req_rd_en), .req_empty(req_empty), .req_dout(req_dout),
    .core_wr_en(core_wr_en), .core_full(core_full), .core_din(core_din),
    .core_rsp_rd_en(core_rsp_rd_en), .core_rsp_empty(core_rsp_empty),
    .core_rsp_dout(core_rsp_dout),
    .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full), .rsp_din(rsp_din),
    .stat_drop_cnt(stat_drop_cnt), .busy(busy)
  );

  FIFO_NETTLP_CMD_T req_q [NREQ][$];
  FIFO_NETTLP_CMD_T eng_q [$];
  FIFO_NETTLP_CMD_T exp_cmd [$];
  FIFO_NETTLP_CMD_T exp_rsp [$];
  int               exp_rsp_idx [$];

  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cnt = 0, pop_cnt = 0, rspw_cnt = 0;
  FIFO_NETTLP_CMD_T mon_e;
  int               mon_i;

  function automatic FIFO_NETTLP_CMD_T mk(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] d);
    FIFO_NETTLP_CMD_T c;
    c.opcode = op;
    c.dwaddr = a;
    c.data   = d;
    return c;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_empty[i] = (req_q[i].size() == 0);
      req_dout[i]  = req_empty[i] ? '0 : req_q[i][0];
    end
    core_rsp_empty = (eng_q.size() == 0);
    core_rsp_dout  = core_rsp_empty ? '0 : eng_q[0];
  endtask

  // Monitor: consumes pops/pushes and scores forwarded commands and responses.
  always @(negedge clk) begin
    if (core_wr_en) begin
      wr_cnt++;
      if (core_din.opcode == NETTLP_OPC_REG_RD) rd_cnt++;
      if (exp_cmd.size() == 0) fail_now("core_wr_en", "unexpected push, required none");
      else begin
        mon_e = exp_cmd.pop_front();
        chk("core_din", 128'(core_din), 128'(mon_e));
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_rd_en[i]) begin
        pop_cnt++;
        if (req_q[i].size() > 0) void'(req_q[i].pop_front());
        else fail_now("req_rd_en", "pop of empty requester FIFO");
      end
    end
    if (core_rsp_rd_en) begin
      if (eng_q.size() > 0) void'(eng_q.pop_front());
      else fail_now("core_rsp_rd_en", "pop of empty engine FIFO");
    end
    if (rsp_wr_en != '0) begin
      rspw_cnt++;
      if (exp_rsp.size() == 0) fail_now("rsp_wr_en", "unexpected response push, required none");
      else begin
        mon_i = exp_rsp_idx.pop_front();
        mon_e = exp_rsp.pop_front();
        chk("rsp_wr_en", 128'(rsp_wr_en), 128'(NREQ'(1) << mon_i));
        chk("rsp_din", 128'(rsp_din), 128'(mon_e));
      end
    end
    drive_inputs();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  function automatic bit all_done();
    bit d = !busy && (exp_cmd.size() == 0) && (exp_rsp.size() == 0) && (eng_q.size() == 0);
    for (int i = 0; i < int'(NREQ); i++) d = d && (req_q[i].size() == 0);
    return d;
  endfunction

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      smp();
      done = all_done();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_rd(input string name, input int target);
    for (int c = 0; c < 20 && rd_cnt < target; c++) smp();
    chk(name, 128'(rd_cnt), 128'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_req_rd_en"}, 128'(req_rd_en), 128'(0));
    chk({tag, "_core_wr_en"}, 128'(core_wr_en), 128'(0));
    chk({tag, "_core_rsp_rd_en"}, 128'(core_rsp_rd_en), 128'(0));
    chk({tag, "_rsp_wr_en"}, 128'(rsp_wr_en), 128'(0));
    chk({tag, "_core_din"}, 128'(core_din), 128'(0));
    chk({tag, "_rsp_din"}, 128'(rsp_din), 128'(0));
    chk({tag, "_drop"}, 128'(stat_drop_cnt), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    FIFO_NETTLP_CMD_T c;
    int w0, p0, r0, n;
    logic [15:0] d0;
    core_full = 1'b0;
    rsp_full  = '0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    tick();
    rst_n = 1'b1;

    // Single write from requester 0: one-cycle issue, two cycles back to idle.
    tick();
    c = mk(NETTLP_OPC_REG_WR, 32'd1, 32'hAABBCCDD);
    req_q[0].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    @(posedge clk);
    smp();
    chk("t1_wr_en", 128'(core_wr_en), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    smp();
    chk("t1_idle", 128'(busy), 128'(0));
    chk("t1_wr_cnt", 128'(wr_cnt), 128'(1));

    // Requester 1 reads MAGIC; engine answers 3 cycles later.
    tick();
    c = mk(NETTLP_OPC_REG_RD, MAGIC, 32'h0);
    req_q[1].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    wait_rd("t3_rd_issued", 1);
    repeat (3) tick();
    c = mk(NETTLP_OPC_REG_RD, MAGIC, 32'h67452301);
    eng_q.push_back(c);
    exp_rsp.push_back(c);
    exp_rsp_idx.push_back(1);
    drive_inputs();
    @(posedge clk);
    smp();
    chk("t3_rsp_wr_en", 128'(rsp_wr_en), 128'(2'b10));
    chk("t3_rsp_data", 128'(rsp_din.data), 128'(32'h67452301));
    wait_done("t3_done", 10);

    // Three writes queued on each requester: grants alternate 0,1,0,1,0,1.
    tick();
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      c = mk(NETTLP_OPC_REG_WR, 32'(16 + k), 32'h0A00_0000 + 32'(k));
      req_q[0].push_back(c);
      exp_cmd.push_back(c);
      c = mk(NETTLP_OPC_REG_WR, 32'(32 + k), 32'h0B00_0000 + 32'(k));
      req_q[1].push_back(c);
      exp_cmd.push_back(c);
    end
    drive_inputs();
    wait_done("t2_done", 40);
    chk("t2_wr_cnt", 128'(wr_cnt - w0), 128'(6));

    // Read to an unmapped address times out; the queued write follows.
    tick();
    w0 = wr_cnt;
    d0 = stat_drop_cnt;
    c = mk(NETTLP_OPC_REG_RD, 32'h0000_0FFF, 32'h0);
    req_q[0].push_back(c);
    exp_cmd.push_back(c);
    c = mk(NETTLP_OPC_REG_WR, 32'd2, 32'h11223344);
    req_q[1].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    wait_rd("t4_rd_issued", 2);
    n = 0;
    while (stat_drop_cnt == d0 && n < 40) begin
      smp();
      n++;
    end
    chk("t4_tmo_cycles", 128'(n), 128'(RSP_TIMEOUT + 1));
    chk("t4_no_wr_during_rd", 128'(wr_cnt - w0), 128'(1));
    wait_done("t4_done", 10);
    chk("t4_drop", 128'(stat_drop_cnt), 128'(1));

    // Engine FIFO full blocks a pending write.
    tick();
    core_full = 1'b1;
    p0 = pop_cnt;
    c = mk(NETTLP_OPC_REG_WR, 32'd3, 32'h55667788);
    req_q[0].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    repeat (6) smp();
    chk("t5_full_no_pop", 128'(pop_cnt - p0), 128'(0));
    tick();
    core_full = 1'b0;
    wait_done("t5a_done", 10);

    // Response held while the owner's response FIFO is full, no timeout.
    tick();
    c = mk(NETTLP_OPC_REG_RD, 32'd4, 32'h0);
    req_q[1].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    wait_rd("t5_rd_issued", 3);
    tick();
    rsp_full[1] = 1'b1;
    r0 = rspw_cnt;
    c = mk(NETTLP_OPC_REG_RD, 32'd4, 32'hCAFEF00D);
    eng_q.push_back(c);
    exp_rsp.push_back(c);
    exp_rsp_idx.push_back(1);
    drive_inputs();
    repeat (20) smp();
    chk("t5_held_no_rsp", 128'(rspw_cnt - r0), 128'(0));
    chk("t5_held_drop", 128'(stat_drop_cnt), 128'(1));
    chk("t5_held_busy", 128'(busy), 128'(1));
    tick();
    rsp_full[1] = 1'b0;
    wait_done("t5b_done", 10);
    chk("t5_delivered", 128'(rspw_cnt - r0), 128'(1));

    // Bad opcode is popped and dropped even while the engine FIFO is full.
    tick();
    core_full = 1'b1;
    w0 = wr_cnt;
    req_q[0].push_back(mk(8'h7F, 32'd9, 32'hDEADBEEF));
    drive_inputs();
    wait_done("t6_done", 10);
    chk("t6_drop", 128'(stat_drop_cnt), 128'(2));
    chk("t6_no_fwd", 128'(wr_cnt - w0), 128'(0));
    tick();
    core_full = 1'b0;

    // Reset during WAIT_RSP; the late response is later drained as stray.
    tick();
    c = mk(NETTLP_OPC_REG_RD, 32'd5, 32'h0);
    req_q[1].push_back(c);
    exp_cmd.push_back(c);
    drive_inputs();
    wait_rd("t7_rd_issued", 4);
    repeat (3) tick();
    chk("t7_pre_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t7_rst");
    tick();
    rst_n = 1'b1;
    tick();
    eng_q.push_back(mk(NETTLP_OPC_REG_RD, 32'd5, 32'h12345678));
    drive_inputs();
    wait_done("t7_done", 10);
    chk("t7_stray_drop", 128'(stat_drop_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
